// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory responder: lane geometry,
// posted-write buffer field widths, timer address and a lane-merge helper.
// The buffer word-index field width equals the ADDR_W parameter of the memory.
package data_mem_pkg;

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int LANES  = DATA_W / LANE_W;

  // Posted-write buffer entry fields (index width follows ADDR_W)
  localparam int BUF_VALID_W = 1;
  localparam int BUF_DATA_W  = DATA_W;
  localparam int BUF_SEL_W   = LANES;

  localparam logic [31:0] TIMER_ADDR = 32'h1000_0000;

  // Replace every lane of base whose sel bit is set with the same lane of over
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0]    base,
    input logic [DATA_W-1:0]    over,
    input logic [BUF_SEL_W-1:0] sel
  );
    logic [DATA_W-1:0] result;
    result = base;
    for (int k = 0; k < LANES; k++) begin
      if (sel[k]) result[k*LANE_W +: LANE_W] = over[k*LANE_W +: LANE_W];
    end
    return result;
  endfunction

endpackage

// File: rtl/data_mem_wbuf.sv
// Single-entry posted-write buffer: captures each RAM write, commits the
// previous entry on the following edge, and forwards buffered lanes to reads
// of the same word so that writes appear to take effect immediately.
module data_mem_wbuf
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    wr_index,
  input  logic [BUF_DATA_W-1:0] wr_data,
  input  logic [BUF_SEL_W-1:0] wr_sel,
  input  logic [ADDR_W-1:0]    rd_index,
  input  logic [DATA_W-1:0]    rd_base,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 commit,
  output logic [ADDR_W-1:0]    commit_index,
  output logic [BUF_DATA_W-1:0] commit_data,
  output logic [BUF_SEL_W-1:0] commit_sel
);

  logic [BUF_VALID_W-1:0] valid;
  logic [ADDR_W-1:0]      index;
  logic [BUF_DATA_W-1:0]  data;
  logic [BUF_SEL_W-1:0]   sel;

  // Hold the newest write; the entry is drained on any edge without a new write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      index <= '0;
      data  <= '0;
      sel   <= '0;
    end else begin
      valid <= wr;
      if (wr) begin
        index <= wr_index;
        data  <= wr_data;
        sel   <= wr_sel;
      end
    end
  end

  // A valid entry is written into the array on every edge it is held
  assign commit       = valid[0];
  assign commit_index = index;
  assign commit_data  = data;
  assign commit_sel   = sel;

  // Overlay buffered lanes onto the array word when the read hits the entry
  always_comb begin
    rd_data = rd_base;
    if (valid[0] && (index == rd_index)) rd_data = merge_lanes(rd_base, data, sel);
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory responder: 2^ADDR_W x 32-bit array with byte lanes, a posted
// write buffer and zero-latency reads. Defining DATA_MEM_TIMER_EN maps a
// free-running cycle counter at TIMER_ADDR that bypasses array and buffer.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0]    word_index;
  logic [DATA_W-1:0]    mem_word;
  logic [DATA_W-1:0]    fwd_data;
  logic                 ram_write;
  logic                 commit;
  logic [ADDR_W-1:0]    commit_index;
  logic [BUF_DATA_W-1:0] commit_data;
  logic [BUF_SEL_W-1:0] commit_sel;
  logic                 unused_addr;

  // Address bits outside the word index only matter for the timer compare
  assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
  assign word_index  = addr_i[ADDR_W+1:2];
  assign mem_word    = mem[word_index];

`ifdef DATA_MEM_TIMER_EN
  logic        is_timer;
  logic [31:0] counter;

  assign is_timer  = (addr_i == TIMER_ADDR);
  assign ram_write = ce_i && we_i && !is_timer;

  // Free-running counter; a timer write loads selected lanes, the rest advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
    end else if (ce_i && we_i && is_timer) begin
      counter <= merge_lanes(counter + 32'd1, data_i, sel_i);
    end else begin
      counter <= counter + 32'd1;
    end
  end
`else
  assign ram_write = ce_i && we_i;
`endif

  data_mem_wbuf #(
    .ADDR_W(ADDR_W)
  ) u_wbuf (
    .clk          (clk),
    .rst          (rst),
    .wr           (ram_write),
    .wr_index     (word_index),
    .wr_data      (data_i),
    .wr_sel       (sel_i),
    .rd_index     (word_index),
    .rd_base      (mem_word),
    .rd_data      (fwd_data),
    .commit       (commit),
    .commit_index (commit_index),
    .commit_data  (commit_data),
    .commit_sel   (commit_sel)
  );

  // Array is never reset; only lanes selected by the drained entry change
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int k = 0; k < LANES; k++) begin
        if (commit_sel[k]) mem[commit_index][k*LANE_W +: LANE_W] <= commit_data[k*LANE_W +: LANE_W];
      end
    end
  end

  // Read data only for an enabled read outside reset, otherwise zero
  always_comb begin
    data_o = '0;
    if (rst && ce_i && !we_i) begin
`ifdef DATA_MEM_TIMER_EN
      if (is_timer) data_o = counter;
      else          data_o = fwd_data;
`else
      data_o = fwd_data;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed scenarios with literal
// expectations plus randomized traffic against an architectural memory model.
// Build with DATA_MEM_TIMER_EN defined to exercise the cycle counter.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [0:1023];
  logic [31:0] timer_model;
  bit          pend = 1'b0;
  int          pend_idx;
  logic [31:0] pend_old;

  bit          lit_valid = 1'b0;
  logic [31:0] lit_exp;
  string       lit_name;

  data_mem_resp #(
    .ADDR_W(10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ce_i   (ce_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .sel_i  (sel_i),
    .data_i (data_i),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic bit hits_timer(input logic [31:0] addr);
`ifdef DATA_MEM_TIMER_EN
    return addr == 32'h1000_0000;
`else
    return addr != addr;
`endif
  endfunction

  // Architectural model: writes land at their edge; a reset before the next
  // edge takes back the most recent write; the timer counts edges since reset.
  always @(posedge clk or negedge rst) begin
    int idx;
    bit tw;
    if (!rst) begin
      if (pend) mem_model[pend_idx] = pend_old;
      pend = 1'b0;
      timer_model = 32'd0;
    end else begin
      tw = ce_i && we_i && hits_timer(addr_i);
      if (ce_i && we_i && !tw) begin
        idx = int'(addr_i[11:2]);
        pend = 1'b1;
        pend_idx = idx;
        pend_old = mem_model[idx];
        mem_model[idx] = lane_merge(mem_model[idx], data_i, sel_i);
      end else begin
        pend = 1'b0;
      end
      timer_model = tw ? lane_merge(timer_model + 32'd1, data_i, sel_i) : timer_model + 32'd1;
    end
  end

  // Compare every cycle against the model and any pending literal expectation
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst || !ce_i || we_i)    exp = 32'd0;
    else if (hits_timer(addr_i)) exp = timer_model;
    else                          exp = mem_model[int'(addr_i[11:2])];
    checks++;
    if (data_o !== exp) begin
      errors++;
      $display("[TB] FAIL model t=%0t addr=%h got %h expected %h", $time, addr_i, data_o, exp);
    end
    if (lit_valid) begin
      checks++;
      if (data_o !== lit_exp) begin
        errors++;
        $display("[TB] FAIL %s got %h expected %h", lit_name, data_o, lit_exp);
      end
    end
  end

  task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] data);
    ce_i = ce;
    we_i = we;
    addr_i = addr;
    sel_i = sel;
    data_i = data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    lit_name = name;
    lit_exp = exp;
    lit_valid = 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r;
    int widx;
    logic [31:0] rnd;
    logic [31:0] a;

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    checkOutput("reset_idle", 32'h0);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    checkOutput("reset_read", 32'h0);
    cycle();
    rst = 1'b1;

    $display("[TB] initialising words 0..63");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(i * 4), 4'hF, 32'hA500_0000 | 32'(i));
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle();

    applyStimulus(1'b1, 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF);
    checkOutput("write_is_zero", 32'h0);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    checkOutput("forward_full", 32'hDEAD_BEEF);
    cycle();

    applyStimulus(1'b1, 1'b1, 32'h40, 4'hF, 32'h1122_3344);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    applyStimulus(1'b1, 1'b1, 32'h40, 4'b0101, 32'hAABB_CCDD);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
    checkOutput("forward_lanes", 32'h11BB_33DD);
    cycle();

    applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'd1);
    cycle();
    applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'd2);
    cycle();
    applyStimulus(1'b1, 1'b1, 32'h14, 4'hF, 32'd3);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    checkOutput("order_0x10", 32'd2);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
    checkOutput("order_0x14", 32'd3);
    cycle();

    applyStimulus(1'b1, 1'b1, 32'h14, 4'h0, 32'hFFFF_FFFF);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
    checkOutput("sel_zero_write", 32'd3);
    cycle();

    applyStimulus(1'b0, 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF);
    checkOutput("ce_off_write", 32'h0);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
    checkOutput("ce_off_read", 32'h0);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'hFFFF_F043, 4'h0, 32'h0);
    checkOutput("alias_read", 32'h11BB_33DD);
    cycle();

    applyStimulus(1'b1, 1'b1, 32'h80, 4'hF, 32'h77);
    cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle();
    applyStimulus(1'b1, 1'b1, 32'h80, 4'hF, 32'h5);
    cycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
    checkOutput("rst_read_zero", 32'h0);
    cycle();
    rst = 1'b1;
    checkOutput("rst_discard", 32'h77);
    cycle();

`ifdef DATA_MEM_TIMER_EN
    applyStimulus(1'b1, 1'b1, 32'h1000_0000, 4'hF, 32'hFFFF_FFFE);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 4'hF, 32'h0);
    checkOutput("timer_load", 32'hFFFF_FFFE);
    cycle();
    checkOutput("timer_max", 32'hFFFF_FFFF);
    cycle();
    checkOutput("timer_wrap", 32'h0);
    cycle();
    applyStimulus(1'b1, 1'b1, 32'h1000_0000, 4'b0001, 32'h0000_00AB);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 4'hF, 32'h0);
    checkOutput("timer_partial", 32'h0000_00AB);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    checkOutput("timer_bypass_ram", 32'hA500_0000);
    cycle();
`else
    applyStimulus(1'b1, 1'b1, 32'h1000_0000, 4'hF, 32'hCAFE_0000);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
    checkOutput("timer_addr_alias", 32'hCAFE_0000);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h1000_0000, 4'hF, 32'h0);
    checkOutput("timer_addr_ram", 32'hCAFE_0000);
    cycle();
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      rnd = $urandom();
      widx = $urandom_range(0, 63);
      a = {rnd[31:12], 4'b0000, widx[5:0], rnd[1:0]};
      if ($urandom_range(0, 99) < 6) a = 32'h1000_0000;
      rst = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if (r < 40)      applyStimulus(1'b1, 1'b0, a, 4'($urandom()), 32'h0);
      else if (r < 75) applyStimulus(1'b1, 1'b1, a, 4'($urandom()), $urandom());
      else             applyStimulus(1'b0, 1'($urandom()), a, 4'($urandom()), $urandom());
      cycle();
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port ce_i  input  1  access enable from the CPU data port.
REQ-005 SHALL have port we_i  input  1  1=write, 0=read, qualified by ce_i.
REQ-006 SHALL have port addr_i  input  32  byte address; word index = addr_i[ADDR_W+1:2].
REQ-007 SHALL have port sel_i  input  4  byte-lane enables; sel_i[k] covers data bits 8k+7:8k.
REQ-008 SHALL have port data_i  input  32  write data.
REQ-009 SHALL have port data_o  output  32  read data, combinational, same cycle as request.

Function
REQ-010 SHALL hold one posted-write buffer entry: valid, word index, data, sel.
REQ-011 SHALL, on an edge with ce_i=1 and we_i=1, commit any valid buffer entry to the array (selected lanes only) and capture the new write into the buffer (valid=1).
REQ-012 SHALL, on an edge without a write and with buffer valid, commit the entry and clear valid.
REQ-013 SHALL never lose or reorder writes: back-to-back writes to the same word apply in program order.
REQ-014 SHALL drive data_o, when ce_i=1 and we_i=0, as array word with each lane k replaced by buffer data lane k when buffer valid, index matches, and buffered sel[k]=1.
REQ-015 SHALL drive data_o=0 when ce_i=0, when we_i=1, or while rst=0.
REQ-016 SHALL ignore addr_i bits above ADDR_W+1 (aliasing) and addr_i[1:0] for RAM accesses.
REQ-017 SHALL ignore sel_i on reads (full word returned); a write with sel_i=0 SHALL occupy the buffer but change no bytes.
REQ-018 SHALL have zero-cycle read latency and one-edge write acceptance; no stall or ready signal exists.

Reset
REQ-019 SHALL clear buffer valid asynchronously when rst=0; a pending buffered write SHALL be discarded.
REQ-020 SHALL not initialise array contents on reset.
REQ-021 SHALL accept no writes while rst=0.

Configuration
REQ-022 SHALL, with DATA_MEM_TIMER_EN defined, map a 32-bit free-running cycle counter at byte address 32'h1000_0000 (full 32-bit compare, word-aligned).
REQ-023 SHALL, with DATA_MEM_TIMER_EN, reset the counter to 0, increment it every edge, and wrap 32'hFFFF_FFFF to 0.
REQ-024 SHALL, with DATA_MEM_TIMER_EN, return the counter on reads of the timer address, bypassing the array and the buffer.
REQ-025 SHALL, with DATA_MEM_TIMER_EN, on a timer-address write, load selected lanes from data_i and unselected lanes from counter+1; the write SHALL not enter the buffer or the array.
REQ-026 SHALL, without DATA_MEM_TIMER_EN, treat 32'h1000_0000 as an ordinary aliased RAM address and contain no counter logic.

Structure
REQ-027 SHALL place TIMER_ADDR, lane width (8), and the buffer-entry field widths in the shared package data_mem_pkg.
REQ-028 SHALL implement the buffer, commit logic, and lane-merge forwarding in sub-module data_mem_wbuf; the array and timer SHALL stay in data_mem_resp.

Verification
REQ-029 SHALL cover: write 32'hDEADBEEF sel=4'hF to 0x40, read 0x40 the next cycle (forwarded) -> data_o=32'hDEADBEEF.
REQ-030 SHALL cover: word 0x40=32'h11223344, write 32'hAABBCCDD sel=4'b0101, read same cycle after edge -> 32'h11BB33DD.
REQ-031 SHALL cover: writes 0x10=1, 0x10=2, 0x14=3 on consecutive edges, then idle, then reads -> 0x10=2, 0x14=3.
REQ-032 SHALL cover: write 32'h5 to 0x80, assert rst=0 before the next edge, release, read 0x80 -> prior array content (write discarded), data_o=0 during reset.
REQ-033 SHALL cover, with DATA_MEM_TIMER_EN: write 32'hFFFF_FFFE sel=4'hF to 32'h1000_0000, read on the following two edges -> 32'hFFFF_FFFE then 32'hFFFF_FFFF, then wrap to 0.
REQ-034 SHALL cover: ce_i=0 with any address -> data_o=0 and no array change.
